// File: rtl/addition_pkg.sv
// Shared constants and types for the floating-point addition datapath.
package addition_pkg;

  localparam int unsigned MENT_WIDTH_DEF = 23;
  localparam int unsigned EXPO_WIDTH_DEF = 8;
  localparam int unsigned TAG_WIDTH_DEF  = 4;
  localparam int unsigned SIG_W_DEF      = MENT_WIDTH_DEF + 1;

  // Guard, round and sticky: the bits kept below the aligned significand.
  localparam int unsigned GRS_BITS = 3;

  typedef struct packed {
    logic guard;
    logic round;
    logic sticky;
  } grs_t;

endpackage : addition_pkg

// File: rtl/addition_rshift_sticky.sv
// Right-shifts a significand by a saturating amount and produces guard/round/sticky.
module addition_rshift_sticky
  import addition_pkg::*;
#(
  parameter int unsigned SIG_W      = SIG_W_DEF,
  parameter int unsigned EXPO_WIDTH = EXPO_WIDTH_DEF
) (
  input  logic [SIG_W-1:0]      sig,
  input  logic [EXPO_WIDTH-1:0] shamt,
  output logic [SIG_W-1:0]      aligned,
  output grs_t                  grs
);

  // Significand extended with guard and round positions; sticky is folded separately.
  localparam int unsigned EXT_W = SIG_W + GRS_BITS - 1;

  logic [EXT_W-1:0] ext;
  logic [EXT_W-1:0] ext_shifted;
  logic [31:0]      shamt_w;
  logic             sticky_acc;

  assign ext     = {sig, {(GRS_BITS - 1){1'b0}}};
  assign shamt_w = 32'(shamt);

  // Logical shift saturates to zero for large amounts; sticky ORs every bit pushed past round.
  always_comb begin
    ext_shifted = ext >> shamt;
    sticky_acc  = 1'b0;
    for (int unsigned i = 0; i < SIG_W; i++) begin
      if (shamt_w >= 32'(i + GRS_BITS)) begin
        sticky_acc = sticky_acc | sig[i];
      end
    end
  end

  assign aligned    = ext_shifted[EXT_W-1:GRS_BITS-1];
  assign grs.guard  = ext_shifted[1];
  assign grs.round  = ext_shifted[0];
  assign grs.sticky = sticky_acc;

endmodule : addition_rshift_sticky

// File: rtl/addition_align_pipe.sv
// Two-stage elastic pipeline aligning the smaller operand's significand for addition.
module addition_align_pipe
  import addition_pkg::*;
#(
  parameter  int unsigned MENT_WIDTH = MENT_WIDTH_DEF,
  parameter  int unsigned EXPO_WIDTH = EXPO_WIDTH_DEF,
  parameter  int unsigned TAG_WIDTH  = TAG_WIDTH_DEF,
  localparam int unsigned SIG_W      = MENT_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SIG_W-1:0]      smaller_sig_in,
  input  logic [EXPO_WIDTH-1:0] rshift_in,
  input  logic [TAG_WIDTH-1:0]  tag_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SIG_W-1:0]      aligned_sig_out,
  output logic                  guard_out,
  output logic                  round_out,
  output logic                  sticky_out,
  output logic [TAG_WIDTH-1:0]  tag_out
);

  // Stage A: captured operand.
  logic                  valid_a;
  logic [SIG_W-1:0]      sig_a;
  logic [EXPO_WIDTH-1:0] shamt_a;
  logic [TAG_WIDTH-1:0]  tag_a;

  // Stage B: aligned result.
  logic                  valid_b;
  logic [SIG_W-1:0]      aligned_b;
  grs_t                  grs_b;
  logic [TAG_WIDTH-1:0]  tag_b;

  logic [SIG_W-1:0]      aligned_c;
  grs_t                  grs_c;
  logic                  adv_b_c;
  logic                  move_a_c;
  logic                  accept_c;

  // Stage B frees up when empty or emitting; stage A moves into it when it does.
  assign adv_b_c  = !valid_b || out_ready;
  assign move_a_c = valid_a && adv_b_c;
  assign in_ready = rst_n && !flush && (!valid_a || adv_b_c);
  assign accept_c = in_valid && in_ready;

  addition_rshift_sticky #(
    .SIG_W      (SIG_W),
    .EXPO_WIDTH (EXPO_WIDTH)
  ) u_rshift (
    .sig     (sig_a),
    .shamt   (shamt_a),
    .aligned (aligned_c),
    .grs     (grs_c)
  );

  // Stage A register: loads on an accepted transfer, empties when its contents move on.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_a <= 1'b0;
      sig_a   <= '0;
      shamt_a <= '0;
      tag_a   <= '0;
    end else begin
      if (flush) begin
        valid_a <= 1'b0;
      end else if (accept_c) begin
        valid_a <= 1'b1;
      end else if (move_a_c) begin
        valid_a <= 1'b0;
      end
      if (accept_c) begin
        sig_a   <= smaller_sig_in;
        shamt_a <= rshift_in;
        tag_a   <= tag_in;
      end
    end
  end

  // Stage B register: loads shifted result from stage A, holds while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_b   <= 1'b0;
      aligned_b <= '0;
      grs_b     <= '0;
      tag_b     <= '0;
    end else begin
      if (flush) begin
        valid_b <= 1'b0;
      end else if (move_a_c) begin
        valid_b <= 1'b1;
      end else if (out_ready) begin
        valid_b <= 1'b0;
      end
      if (move_a_c) begin
        aligned_b <= aligned_c;
        grs_b     <= grs_c;
        tag_b     <= tag_a;
      end
    end
  end

  assign out_valid       = valid_b;
  assign aligned_sig_out = aligned_b;
  assign guard_out       = grs_b.guard;
  assign round_out       = grs_b.round;
  assign sticky_out      = grs_b.sticky;
  assign tag_out         = tag_b;

endmodule : addition_align_pipe

// File: tb/tb_addition_align_pipe.sv
// Randomized and directed bench for addition_align_pipe against a behavioural model.
module tb_addition_align_pipe;

  localparam int unsigned SIG_W      = 24;
  localparam int unsigned EXPO_WIDTH = 8;
  localparam int unsigned TAG_WIDTH  = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [SIG_W-1:0]      smaller_sig_in;
  logic [EXPO_WIDTH-1:0] rshift_in;
  logic [TAG_WIDTH-1:0]  tag_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [SIG_W-1:0]      aligned_sig_out;
  logic                  guard_out;
  logic                  round_out;
  logic                  sticky_out;
  logic [TAG_WIDTH-1:0]  tag_out;

  always #5 clk = ~clk;

  addition_align_pipe #(
    .MENT_WIDTH (SIG_W - 1),
    .EXPO_WIDTH (EXPO_WIDTH),
    .TAG_WIDTH  (TAG_WIDTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .smaller_sig_in  (smaller_sig_in),
    .rshift_in       (rshift_in),
    .tag_in          (tag_in),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .aligned_sig_out (aligned_sig_out),
    .guard_out       (guard_out),
    .round_out       (round_out),
    .sticky_out      (sticky_out),
    .tag_out         (tag_out)
  );

  typedef struct {
    logic [SIG_W-1:0]     aligned;
    logic                 g;
    logic                 r;
    logic                 s;
    logic [TAG_WIDTH-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks   = 0;
  int   n_pass     = 0;
  int   n_emit     = 0;
  bit   rand_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
  endtask

  // Reference: alignment defined directly from the bit positions of S and shift k.
  function automatic exp_t model(input logic [SIG_W-1:0] s, input int unsigned k,
                                 input logic [TAG_WIDTH-1:0] t);
    exp_t e;
    e.aligned = '0;
    e.g = 1'b0;
    e.r = 1'b0;
    e.s = 1'b0;
    e.tag = t;
    if (k < SIG_W) e.aligned = s >> k;
    if (k >= 1 && k <= SIG_W) e.g = s[k-1];
    if (k >= 2 && k <= SIG_W + 1) e.r = s[k-2];
    for (int unsigned j = 0; j < SIG_W; j++) begin
      if (k >= 3 && j <= k - 3) e.s = e.s | s[j];
    end
    return e;
  endfunction

  // Scoreboard: records accepts, checks emissions in order, and checks stall stability.
  logic                           hold_prev = 1'b0;
  logic [SIG_W+3+TAG_WIDTH-1:0]   held;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'({aligned_sig_out, guard_out, round_out, sticky_out, tag_out}), 64'(held));
      end
      if (out_valid && out_ready) begin
        n_emit++;
        chk("emit_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("emit_data", 64'({aligned_sig_out, guard_out, round_out, sticky_out}),
              64'({e.aligned, e.g, e.r, e.s}));
          chk("emit_tag", 64'(tag_out), 64'(e.tag));
        end
      end
      hold_prev = out_valid && !out_ready && !flush;
      held = {aligned_sig_out, guard_out, round_out, sticky_out, tag_out};
      if (flush) exp_q.delete();
      else if (in_valid && in_ready)
        exp_q.push_back(model(smaller_sig_in, 32'(rshift_in), tag_in));
    end
  end

  // Random backpressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Present one operand (caller is just past a rising edge) and hold it until accepted.
  task automatic push(input logic [SIG_W-1:0] s, input int unsigned k, input logic [TAG_WIDTH-1:0] t);
    bit ok;
    smaller_sig_in = s;
    rshift_in      = EXPO_WIDTH'(k);
    tag_in         = t;
    in_valid       = 1'b1;
    ok             = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("push_accepted", 64'(ok), 64'd1);
  endtask

  // Single operand with out_ready high: checks 2-cycle latency and hand-computed result.
  task automatic dir(input logic [SIG_W-1:0] s, input int unsigned k, input logic [TAG_WIDTH-1:0] t,
                     input logic [SIG_W-1:0] exp_al, input logic [2:0] exp_grs);
    int lat;
    push(s, k, t);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
    chk("dir_latency", 64'(lat), 64'd2);
    chk("dir_result", 64'({aligned_sig_out, guard_out, round_out, sticky_out}), 64'({exp_al, exp_grs}));
    chk("dir_tag", 64'(tag_out), 64'(t));
    sync();
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) @(posedge clk);
    @(negedge clk);
    chk(name, 64'(exp_q.size()), 64'd0);
    sync();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    smaller_sig_in = '0; rshift_in = '0; tag_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_outputs", 64'({aligned_sig_out, guard_out, round_out, sticky_out, tag_out}), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", 64'(in_ready), 64'd1);
    sync();

    // Hand-computed alignments, including boundaries of k.
    dir(24'h800000,   1, 4'h1, 24'h400000, 3'b000);
    dir(24'h800001,   2, 4'h2, 24'h200000, 3'b010);
    dir(24'h800007,   4, 4'h3, 24'h080000, 3'b011);
    dir(24'h800001,  30, 4'h4, 24'h000000, 3'b001);
    dir(24'h800001, 255, 4'h5, 24'h000000, 3'b001);
    dir(24'h800001,   0, 4'h6, 24'h800001, 3'b000);
    dir(24'hABCDEF,  24, 4'h7, 24'h000000, 3'b101);
    dir(24'hABCDEF,  25, 4'h8, 24'h000000, 3'b011);
    dir(24'h800000,  26, 4'h9, 24'h000000, 3'b001);
    dir(24'h000004,   3, 4'hA, 24'h000000, 3'b100);

    // Backpressure: two accepted, then stall for 5 cycles, then four emitted in order.
    out_ready = 1'b0;
    e0 = n_emit;
    push(24'h111111, 1, 4'hB);
    push(24'h222222, 2, 4'hC);
    smaller_sig_in = 24'h333333; rshift_in = 8'd3; tag_in = 4'hD; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      sync();
    end
    out_ready = 1'b1;
    push(24'h333333, 3, 4'hD);
    push(24'h444444, 4, 4'hE);
    drain("bp_drain");
    chk("bp_emit_count", 64'(n_emit - e0), 64'd4);

    // Flush with both stages full and a competing input.
    out_ready = 1'b0;
    push(24'h555555, 5, 4'h1);
    push(24'h666666, 6, 4'h2);
    smaller_sig_in = 24'h777777; rshift_in = 8'd7; tag_in = 4'h3; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    sync();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    e0 = n_emit;
    sync();
    out_ready = 1'b1;
    repeat (5) sync();
    chk("flush_no_emit", 64'(n_emit - e0), 64'd0);

    // Reset while a result is waiting.
    out_ready = 1'b0;
    push(24'h888888, 8, 4'h4);
    push(24'h999999, 9, 4'h5);
    @(negedge clk);
    chk("rst_pre_out_valid", 64'(out_valid), 64'd1);
    sync();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_outputs", 64'({aligned_sig_out, guard_out, round_out, sticky_out, tag_out}), 64'd0);
    e0 = n_emit;
    sync();
    out_ready = 1'b1;
    repeat (5) sync();
    chk("rst_no_emit", 64'(n_emit - e0), 64'd0);

    // Randomized traffic with random backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      logic [SIG_W-1:0] s;
      int unsigned k;
      if ($urandom_range(0, 3) == 0) sync();
      s = SIG_W'($urandom);
      if ($urandom_range(0, 1) == 1) s[SIG_W-1] = 1'b1;
      case ($urandom_range(0, 3))
        0:       k = $urandom_range(0, 3);
        1:       k = $urandom_range(0, 26);
        2:       k = $urandom_range(20, 30);
        default: k = $urandom_range(0, 255);
      endcase
      push(s, k, TAG_WIDTH'($urandom));
    end
    rand_ready = 1'b0;
    sync();
    out_ready = 1'b1;
    drain("rand_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_addition_align_pipe
